// File: rtl/game_pkg.sv
// Shared game definitions: game-state encoding, screen geometry and the
// speed-cap helper. Imported by the ship controller, the asteroid/draw
// blocks and the game logic so every block agrees on the same bounds.
package game_pkg;

    // Global game state as driven by the game-logic block
    typedef enum logic [1:0] {
        IDLE           = 2'b00,
        OPENING_SCREEN = 2'b01,
        GAME_RUNNING   = 2'b10,
        GAME_OVER      = 2'b11
    } game_state_e;

    // Playfield bounds for the ship's top-left corner
    localparam int X_MIN   = 50;
    localparam int X_MAX   = 1330;
    localparam int Y_MIN   = 10;
    localparam int Y_MAX   = 750;
    localparam int START_X = 650;
    localparam int START_Y = 750;

    // Width of the gap in the top wall
    localparam int EXIT_W  = 100;

    // Speed ceiling chosen by the switches: one step per raised switch on
    // top of a base speed of 1, never above the absolute ceiling.
    function automatic logic [3:0] speedCap(input logic [2:0] swIn, input int maxSpeed);
        int c;
        c = $countones(swIn) + 1;
        if (c > maxSpeed) begin
            c = maxSpeed;
        end
        return 4'(c);
    endfunction

endpackage

// File: rtl/ship_motion_ctrl_if.sv
// Bundle between the game logic and the ship motion controller.
//   master (game logic): drives game_state, btn {down,right,left,up}, sw, exit_x
//                        and reads back the ship status.
//   slave  (controller): reads the controls and drives pos_x, pos_y, tick,
//                        speed, in_exit, moving.
interface ship_motion_ctrl_if
    import game_pkg::*;
#(
    parameter int POS_W = 11
) ();

    game_state_e      game_state;
    logic [3:0]       btn;
    logic [2:0]       sw;
    logic [POS_W-1:0] exit_x;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic             tick;
    logic [3:0]       speed;
    logic             in_exit;
    logic             moving;

    modport master (
        output game_state, btn, sw, exit_x,
        input  pos_x, pos_y, tick, speed, in_exit, moving
    );

    modport slave (
        input  game_state, btn, sw, exit_x,
        output pos_x, pos_y, tick, speed, in_exit, moving
    );

endinterface

// File: rtl/axis_sat_step.sv
// One axis of ship motion: moves pos by step in the requested direction and
// saturates the result to [lo, hi].
//   pos_i     current coordinate
//   step_i    pixels to move this tick
//   dir_neg_i move towards smaller coordinates
//   dir_pos_i move towards larger coordinates (both set = no move)
//   lo_i/hi_i saturation bounds
//   pos_o     next coordinate
module axis_sat_step #(
    parameter int W = 11
) (
    input  logic [W-1:0] pos_i,
    input  logic [W-1:0] step_i,
    input  logic         dir_neg_i,
    input  logic         dir_pos_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] hi_i,
    output logic [W-1:0] pos_o
);

    // One extra bit of headroom so pos-step never wraps below zero and
    // pos+step never wraps past the top of the coordinate range.
    logic [W:0] posExt;
    logic [W:0] stepExt;
    logic [W:0] loExt;
    logic [W:0] hiExt;

    assign posExt  = {1'b0, pos_i};
    assign stepExt = {1'b0, step_i};
    assign loExt   = {1'b0, lo_i};
    assign hiExt   = {1'b0, hi_i};

    // Compare before subtracting: pos < lo+step is the underflow-free form
    // of pos-step < lo, which also pulls a coordinate already past lo back
    // onto the bound.
    always_comb begin
        pos_o = pos_i;
        if (dir_neg_i && !dir_pos_i) begin
            if (posExt < stepExt + loExt) begin
                pos_o = lo_i;
            end else begin
                pos_o = W'(posExt - stepExt);
            end
        end else if (dir_pos_i && !dir_neg_i) begin
            if (posExt + stepExt > hiExt) begin
                pos_o = hi_i;
            end else begin
                pos_o = W'(posExt + stepExt);
            end
        end
    end

endmodule

// File: rtl/ship_motion_ctrl.sv
// Ship motion controller: derives a movement tick from the system clock and,
// on each tick, moves the ship per axis with a button-hold speed ramp capped
// by the switches. Saturates at the screen bounds and lets the ship through
// the top wall only inside the exit window.
//   clk, rst  system clock, asynchronous active-high reset
//   bus       slave side of ship_motion_ctrl_if (controls in, ship status out)
module ship_motion_ctrl
    import game_pkg::*;
#(
    parameter int POS_W       = 11,
    parameter int TICK_DIV    = 3333334,
    parameter int X_MIN       = game_pkg::X_MIN,
    parameter int X_MAX       = game_pkg::X_MAX,
    parameter int Y_MIN       = game_pkg::Y_MIN,
    parameter int Y_MAX       = game_pkg::Y_MAX,
    parameter int START_X     = game_pkg::START_X,
    parameter int START_Y     = game_pkg::START_Y,
    parameter int SHIP_HALF   = 16,
    parameter int EXIT_W      = game_pkg::EXIT_W,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 8
) (
    input logic              clk,
    input logic              rst,
    ship_motion_ctrl_if.slave bus
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

    localparam logic [POS_W-1:0] XMIN_V   = POS_W'(X_MIN);
    localparam logic [POS_W-1:0] XMAX_V   = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] YMIN_V   = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0] YMAX_V   = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] STARTX_V = POS_W'(START_X);
    localparam logic [POS_W-1:0] STARTY_V = POS_W'(START_Y);
    localparam logic [POS_W:0]   HALF_V   = (POS_W + 1)'(SHIP_HALF);
    localparam logic [POS_W:0]   EXITW_V  = (POS_W + 1)'(EXIT_W);

    logic [CNT_W-1:0]  cnt_q;
    logic              tick_q;
    logic [POS_W-1:0]  pos_x_q;
    logic [POS_W-1:0]  pos_y_q;
    logic [3:0]        speed_q;
    logic [HOLD_W-1:0] hold_q;
    logic              inExit_q;
    logic              moving_q;

    logic [POS_W-1:0]  pos_x_d;
    logic [POS_W-1:0]  pos_y_d;
    logic [3:0]        speed_d;
    logic [HOLD_W-1:0] hold_d;

    logic              btnUp;
    logic              btnLeft;
    logic              btnRight;
    logic              btnDown;
    logic              xDirNeg;
    logic              xDirPos;
    logic              yDirNeg;
    logic              yDirPos;
    logic [POS_W:0]    centreCur;
    logic [POS_W:0]    centreNew;
    logic [POS_W:0]    winLo;
    logic [POS_W:0]    winHi;
    logic              winCur;
    logic              winNew;
    logic [POS_W-1:0]  stepVal;
    logic [POS_W-1:0]  yLo;
    logic [POS_W-1:0]  xCand;
    logic [3:0]        cap;

    // Tick divider. tick_q is raised one count early so that it is high
    // exactly while the counter sits on its last value, i.e. on the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            tick_q <= (cnt_q == CNT_W'(TICK_DIV - 2));
        end
    end

    assign btnUp    = bus.btn[0];
    assign btnLeft  = bus.btn[1];
    assign btnRight = bus.btn[2];
    assign btnDown  = bus.btn[3];

    // Opposing buttons cancel on their own axis only
    assign xDirNeg = btnLeft  & ~btnRight;
    assign xDirPos = btnRight & ~btnLeft;
    assign yDirNeg = btnUp    & ~btnDown;
    assign yDirPos = btnDown  & ~btnUp;

    // Exit window test on the ship centre, before and after the x move
    assign winLo     = {1'b0, bus.exit_x};
    assign winHi     = {1'b0, bus.exit_x} + EXITW_V;
    assign centreCur = {1'b0, pos_x_q} + HALF_V;
    assign centreNew = {1'b0, xCand} + HALF_V;
    assign winCur    = (centreCur >= winLo) && (centreCur <= winHi);
    assign winNew    = (centreNew >= winLo) && (centreNew <= winHi);

    // The step is the speed registered before this tick's ramp update
    assign stepVal = POS_W'(speed_q);

    // Climbing outside the window stops at the wall; inside it the ship may
    // rise to the top of the screen. Downward moves never need the wall.
    assign yLo = (yDirNeg && !winCur) ? YMIN_V : '0;

    axis_sat_step #(.W(POS_W)) xAxis (
        .pos_i     (pos_x_q),
        .step_i    (stepVal),
        .dir_neg_i (xDirNeg),
        .dir_pos_i (xDirPos),
        .lo_i      (XMIN_V),
        .hi_i      (XMAX_V),
        .pos_o     (xCand)
    );

    axis_sat_step #(.W(POS_W)) yAxis (
        .pos_i     (pos_y_q),
        .step_i    (stepVal),
        .dir_neg_i (yDirNeg),
        .dir_pos_i (yDirPos),
        .lo_i      (yLo),
        .hi_i      (YMAX_V),
        .pos_o     (pos_y_d)
    );

    // Inside the gap the ship is boxed in sideways by the wall edges
    assign pos_x_d = ((pos_y_q < YMIN_V) && !winNew) ? pos_x_q : xCand;

    assign cap = speedCap(bus.sw, MAX_SPEED);

    // Speed ramp: every ACCEL_TICKS held ticks add one step up to the cap;
    // a lowered cap pulls the speed down on the very next tick.
    always_comb begin
        speed_d = speed_q;
        hold_d  = hold_q;
        if (bus.btn == 4'b0000) begin
            speed_d = 4'd1;
            hold_d  = '0;
        end else if (hold_q == HOLD_W'(ACCEL_TICKS - 1)) begin
            hold_d  = '0;
            speed_d = (speed_q < cap) ? speed_q + 4'd1 : cap;
        end else begin
            hold_d  = hold_q + 1'b1;
            speed_d = (speed_q > cap) ? cap : speed_q;
        end
    end

    // Ship state, advanced only on tick cycles using the game_state sampled
    // on that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x_q  <= STARTX_V;
            pos_y_q  <= STARTY_V;
            speed_q  <= 4'd1;
            hold_q   <= '0;
            inExit_q <= 1'b0;
            moving_q <= 1'b0;
        end else if (tick_q) begin
            case (bus.game_state)
                OPENING_SCREEN: begin
                    pos_x_q  <= STARTX_V;
                    pos_y_q  <= STARTY_V;
                    speed_q  <= 4'd1;
                    hold_q   <= '0;
                    inExit_q <= 1'b0;
                    moving_q <= 1'b0;
                end
                GAME_RUNNING: begin
                    pos_x_q  <= pos_x_d;
                    pos_y_q  <= pos_y_d;
                    speed_q  <= speed_d;
                    hold_q   <= hold_d;
                    inExit_q <= (pos_y_d < YMIN_V);
                    moving_q <= (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
                end
                default: begin
                    speed_q  <= 4'd1;
                    hold_q   <= '0;
                    inExit_q <= (pos_y_q < YMIN_V);
                    moving_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pos_x   = pos_x_q;
    assign bus.pos_y   = pos_y_q;
    assign bus.tick    = tick_q;
    assign bus.speed   = speed_q;
    assign bus.in_exit = inExit_q;
    assign bus.moving  = moving_q;

endmodule
